// File: rtl/interval_pulse_gen.sv
// interval_pulse_gen
//   Transmit side of the interval-measurement link. Emits a train of npulse_i
//   single-cycle pulses on out_c_o, consecutive pulses spaced by period_i
//   enabled clock cycles (cnt_en_i = 1). A period of 0 means 2^WIDTH cycles.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      latch period/npulse and launch a train (accepted in IDLE/DONE)
//   abort_i      drop the train and return to IDLE; no done indication
//   cnt_en_i     gap-count enable; gap counter and pulse count freeze when 0
//   ack_done_i   clear done, DONE -> IDLE
//   period_i     pulse spacing in enabled cycles
//   npulse_i     number of pulses in the train (0 = empty train)
//   out_c_o      registered pulse output
//   busy_o       high while a train is running
//   done_o       sticky completion flag
//   remaining_o  pulses still to emit after the current one

module interval_pulse_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cnt_en_i,
  input  logic             ack_done_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [CW-1:0]    npulse_i,
  output logic             out_c_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    remaining_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             out_c_q, out_c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      out_c_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      out_c_q  <= out_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    out_c_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    period_d = period_q;

    if (abort_i) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            period_d = period_i;
            if (npulse_i != '0) begin
              state_d = StRun;
              out_c_d = 1'b1;
              // Wraps for period 0, giving the full 2^WIDTH gap.
              cnt_d   = period_i - WIDTH'(1);
              rem_d   = npulse_i - CW'(1);
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end else begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              rem_d   = '0;
            end
          end else if (state_q == StDone && ack_done_i) begin
            state_d = StIdle;
            done_d  = 1'b0;
          end
        end
        StRun: begin
          if (cnt_en_i) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (rem_q != '0) begin
              out_c_d = 1'b1;
              cnt_d   = period_q - WIDTH'(1);
              rem_d   = rem_q - CW'(1);
            end else begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign out_c_o     = out_c_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign remaining_o = rem_q;

endmodule

// File: tb/tb_interval_pulse_gen.sv
module tb_interval_pulse_gen;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CW    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort, cnt_en, ack_done;
  logic [WIDTH-1:0] period;
  logic [CW-1:0]    npulse;
  logic             out_c, busy, done;
  logic [CW-1:0]    remaining;

  int checks = 0;
  int errors = 0;

  interval_pulse_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .cnt_en_i    (cnt_en),
    .ack_done_i  (ack_done),
    .period_i    (period),
    .npulse_i    (npulse),
    .out_c_o     (out_c),
    .busy_o      (busy),
    .done_o      (done),
    .remaining_o (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cnt_en = 1'b0; ack_done = 1'b0;
    period = '0; npulse = '0;
    #2;
    chk("rst_out", 32'(out_c), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // P=5, N=3: pulses at 1, 6, 11; done at 16; busy 1..15.
    period = 16'd5; npulse = 8'd3; cnt_en = 1'b1; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("p5_out_c%0d", c), 32'(out_c), 32'(c == 1 || c == 6 || c == 11));
      chk($sformatf("p5_busy_c%0d", c), 32'(busy), 32'(c <= 15));
      chk($sformatf("p5_done_c%0d", c), 32'(done), 32'(c == 16));
      if (c == 1)  chk("p5_rem1", 32'(remaining), 32'd2);
      if (c == 6)  chk("p5_rem6", 32'(remaining), 32'd1);
      if (c == 11) chk("p5_rem11", 32'(remaining), 32'd0);
      if (c == 3)  period = 16'd1;  // ignored mid-train
    end
    ack_done = 1'b1;
    step();
    ack_done = 1'b0;
    chk("ack_done", 32'(done), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);

    // P=1, N=4: continuous pulses 1..4, remaining 3,2,1,0; done at 5.
    period = 16'd1; npulse = 8'd4; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("p1_out_c%0d", c), 32'(out_c), 32'(c <= 4));
      if (c <= 4) chk($sformatf("p1_rem_c%0d", c), 32'(remaining), 32'(4 - c));
    end
    chk("p1_done", 32'(done), 32'd1);
    ack_done = 1'b1;
    step();
    ack_done = 1'b0;

    // N=0: no pulse, done next cycle.
    npulse = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("n0_out", 32'(out_c), 32'd0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    // start and ackDone together in DONE: start wins. P=2, N=1.
    period = 16'd2; npulse = 8'd1; start = 1'b1; ack_done = 1'b1;
    step();
    start = 1'b0; ack_done = 1'b0;
    chk("sa_out", 32'(out_c), 32'd1);
    chk("sa_done", 32'(done), 32'd0);
    chk("sa_busy", 32'(busy), 32'd1);
    step(); step();
    chk("sa_done_end", 32'(done), 32'd1);
    ack_done = 1'b1;
    step();
    ack_done = 1'b0;

    // P=3, N=2 with cntEn low for 2 cycles after first pulse: second at 6; done at 9.
    period = 16'd3; npulse = 8'd2; cnt_en = 1'b1; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      start = 1'b0;
      chk($sformatf("fz_out_c%0d", c), 32'(out_c), 32'(c == 1 || c == 6));
      chk($sformatf("fz_done_c%0d", c), 32'(done), 32'(c == 9));
      cnt_en = !(c == 1 || c == 2);
    end
    cnt_en = 1'b1;
    ack_done = 1'b1;
    step();
    ack_done = 1'b0;

    // Abort at cycle 3 of P=4, N=3 (abort beats a simultaneous start).
    period = 16'd4; npulse = 8'd3; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      start = 1'b0;
    end
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("ab_out", 32'(out_c), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_rem", 32'(remaining), 32'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("ab_quiet_out%0d", c), 32'(out_c), 32'd0);
      chk($sformatf("ab_quiet_done%0d", c), 32'(done), 32'd0);
    end

    // Reset mid-train while out_c is high: everything clears at once.
    period = 16'd3; npulse = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("mr_pre_out", 32'(out_c), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_out", 32'(out_c), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_rem", 32'(remaining), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("mr_quiet_out%0d", c), 32'(out_c), 32'd0);
      chk($sformatf("mr_quiet_busy%0d", c), 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
